fft_addr_gen: RTL and testbench
===============================

Name: fft_addr_gen

Overview:
- Sequencing controller for the in-place radix-2 DIT FFT engine.
- For each butterfly of each stage it produces the two data-memory addresses and the twiddle-ROM index pair (tw_k, tw_n), with a valid/ready handshake toward the butterfly datapath.
- Sits directly upstream of the twiddle ROM (drives its k and n inputs) and of the butterfly unit. Input data must already be in bit-reversed order in memory.

Parameters:
- MAX_N, 32, largest supported FFT size; power of two, 4..32.
- ADDR_WIDTH, $clog2(MAX_N), data address and twiddle index width.
- LOG2_W, $clog2($clog2(MAX_N)+1), width of n_log2 and stage.
- STAGE_GAP, 2, idle cycles inserted between stages for butterfly pipeline drain; 0 is legal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a transform; sampled only in IDLE
- n_log2  in  LOG2_W  log2 of FFT size; legal range 1..$clog2(MAX_N)
- abort  in  1  synchronous cancel of the current transform
- out_valid  out  1  current address/twiddle set is valid
- out_ready  in  1  butterfly accepts the current set
- addr_a  out  ADDR_WIDTH  upper-leg address
- addr_b  out  ADDR_WIDTH  lower-leg address, addr_a + half
- tw_k  out  ADDR_WIDTH  twiddle index k
- tw_n  out  ADDR_WIDTH+1  twiddle span n (2..MAX_N)
- stage  out  LOG2_W  current stage number
- last  out  1  current set is the final butterfly of the final stage
- busy  out  1  high from the accepted start until the done cycle, inclusive
- done  out  1  one-cycle pulse at transform completion
- err  out  1  one-cycle pulse when start is given with an illegal n_log2

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- All outputs are registered. On reset:
  - FSM goes to IDLE.
  - out_valid, busy, done, err, last = 0.
  - addr_a, addr_b, tw_k, stage = 0; tw_n = 0.
- FSM states: IDLE, RUN, GAP, DONE.
- IDLE:
  - start=1 with legal n_log2: latch L = n_log2 and N = 1<<L; set stage=0, j=0; go to RUN. busy=1 and out_valid=1 with the first set on the next cycle (1-cycle latency).
  - start=1 with illegal n_log2 (0 or > $clog2(MAX_N)): err=1 for one cycle; remain in IDLE.
- Address/twiddle mapping in RUN, for stage s and butterfly index j (0..N/2-1):
  - half = 1<<s; group = j>>s; pos = j & (half-1).
  - addr_a = group*2*half + pos; addr_b = addr_a + half.
  - tw_k = pos; tw_n = 2*half.
- Handshake:
  - A transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, every output holds stable.
  - out_valid never drops without a transfer, except on abort or rst.
- On a transfer in RUN:
  - If j < N/2-1: j++, next set presented the following cycle (no bubble when out_ready stays high).
  - If j == N/2-1 and s < L-1: if STAGE_GAP > 0, go to GAP with out_valid=0 for exactly STAGE_GAP cycles, then RUN with s+1, j=0. If STAGE_GAP = 0, go directly to s+1, j=0 with no bubble.
  - If j == N/2-1 and s == L-1: go to DONE; out_valid=0.
- last is high exactly while the set for s=L-1, j=N/2-1 is presented.
- DONE: done=1 and busy=1 for one cycle, then IDLE with busy=0.
- start while busy is ignored.
- abort=1 in RUN, GAP or DONE: next cycle IDLE; out_valid, busy, last = 0; no done pulse. abort in IDLE has no effect. abort has priority over a simultaneous transfer.
- rst has priority over everything.
- With out_ready held high, total cycles from the start edge to the done cycle = 1 + L*N/2 + (L-1)*STAGE_GAP.
- tw_n is wide enough to carry MAX_N itself, i.e. 32 for MAX_N=32.

Test Plan:
- N=8, STAGE_GAP=0, out_ready=1, start at cycle 0 -> cycles 1..12 present (a,b,k,n):
  - stage 0: (0,1,0,2) (2,3,0,2) (4,5,0,2) (6,7,0,2)
  - stage 1: (0,2,0,4) (1,3,1,4) (4,6,0,4) (5,7,1,4)
  - stage 2: (0,4,0,8) (1,5,1,8) (2,6,2,8) (3,7,3,8)
  - last=1 at cycle 12 only; done=1 at cycle 13; busy low at cycle 14.
- N=32, STAGE_GAP=2, out_ready=1 -> 80 valid beats; 2-cycle out_valid=0 gap after each of stages 0..3; done at cycle 1+80+8=89. In stage 4, tw_n=32 and tw_k runs 0..15.
- N=8, out_ready toggled with a random pattern -> address sequence identical to the first test; outputs hold stable in every cycle where valid && !ready; scoreboard shows no missing or duplicated beats.
- Abort asserted at the 5th valid beat, with out_ready=1 in the same cycle -> next cycle out_valid=0, busy=0, done never pulses. A new start with n_log2=2 (N=4) then yields (0,1,0,2) (2,3,0,2) (0,2,0,4) (1,3,1,4), followed by done.
- start with n_log2=0, then n_log2=6 (MAX_N=32) -> err one-cycle pulse each time; busy, out_valid stay 0. start pulsed during RUN -> ignored, sequence unchanged.
- rst asserted mid-RUN -> next cycle all outputs at their reset values; FSM in IDLE; a subsequent start with N=2 yields a single beat (0,1,0,2) with last=1, then done.

Source files
------------

// File: rtl/fft_addr_gen_if.sv
// Butterfly-side handshake bundle of the FFT address generator:
// address pair, twiddle index/span, stage number and last flag.
interface fft_addr_gen_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int LOG2_W     = 3
);
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [ADDR_WIDTH-1:0] tw_k;
    logic [ADDR_WIDTH:0]   tw_n;
    logic [LOG2_W-1:0]     stage;
    logic                  last;

    modport master (
        output out_valid, addr_a, addr_b, tw_k, tw_n, stage, last,
        input  out_ready
    );

    modport slave (
        input  out_valid, addr_a, addr_b, tw_k, tw_n, stage, last,
        output out_ready
    );
endinterface

// File: rtl/fft_addr_gen.sv
// In-place radix-2 DIT FFT sequencer: walks stages and butterflies,
// emitting memory address pairs and twiddle (k, n) per butterfly.
module fft_addr_gen #(
    parameter int MAX_N      = 32,
    parameter int ADDR_WIDTH = $clog2(MAX_N),
    parameter int LOG2_W     = $clog2($clog2(MAX_N) + 1),
    parameter int STAGE_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LOG2_W-1:0] n_log2,
    input  logic              abort,
    fft_addr_gen_if.master    bus,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int NW = ADDR_WIDTH + 1;
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [GW-1:0] GAP_END = GW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    state_t                state;
    logic [LOG2_W-1:0]     s;
    logic [LOG2_W-1:0]     lmax;
    logic [ADDR_WIDTH-1:0] j;
    logic [ADDR_WIDTH-1:0] jmax;
    logic [GW-1:0]         gcnt;
    logic                  valid_q;
    logic                  last_q;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [ADDR_WIDTH-1:0] b_q;
    logic [ADDR_WIDTH-1:0] k_q;
    logic [NW-1:0]         n_q;

    logic [LOG2_W-1:0]     ld_s;
    logic [ADDR_WIDTH-1:0] ld_j;
    logic [LOG2_W-1:0]     ld_lmax;
    logic [ADDR_WIDTH-1:0] ld_jmax;
    logic [ADDR_WIDTH-1:0] ld_pos;
    logic [ADDR_WIDTH-1:0] ld_a;
    logic [ADDR_WIDTH-1:0] ld_b;
    logic [NW-1:0]         ld_n;
    logic                  ld_last;
    logic                  legal;
    logic                  xfer;

    function automatic logic [ADDR_WIDTH-1:0] jmax_of(input logic [LOG2_W-1:0] l);
        logic [NW-1:0] t;
        t = NW'(1) << l;
        return ADDR_WIDTH'((t >> 1) - NW'(1));
    endfunction

    assign legal = (n_log2 != '0) && (n_log2 <= LOG2_W'(ADDR_WIDTH));
    assign xfer  = valid_q && bus.out_ready;

    // Set to present next: first of a transform, next in stage, or first of next stage.
    always_comb begin
        ld_s    = s;
        ld_j    = j + ADDR_WIDTH'(1);
        ld_lmax = lmax;
        ld_jmax = jmax;
        if (state == IDLE) begin
            ld_s    = '0;
            ld_j    = '0;
            ld_lmax = n_log2 - LOG2_W'(1);
            ld_jmax = jmax_of(n_log2);
        end else if (j == jmax) begin
            ld_s = s + LOG2_W'(1);
            ld_j = '0;
        end
        ld_pos  = ld_j & ~({ADDR_WIDTH{1'b1}} << ld_s);
        ld_a    = (((ld_j >> ld_s) << ld_s) << 1) | ld_pos;
        ld_b    = ld_a | (ADDR_WIDTH'(1) << ld_s);
        ld_n    = NW'(2) << ld_s;
        ld_last = (ld_s == ld_lmax) && (ld_j == ld_jmax);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s       <= '0;
            lmax    <= '0;
            j       <= '0;
            jmax    <= '0;
            gcnt    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && legal) begin
                        state   <= RUN;
                        lmax    <= ld_lmax;
                        jmax    <= ld_jmax;
                        s       <= ld_s;
                        j       <= ld_j;
                        a_q     <= ld_a;
                        b_q     <= ld_b;
                        k_q     <= ld_pos;
                        n_q     <= ld_n;
                        last_q  <= ld_last;
                        valid_q <= 1'b1;
                        busy    <= 1'b1;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy    <= 1'b0;
                    end else if (xfer) begin
                        if (j != jmax || (s != lmax && STAGE_GAP == 0)) begin
                            s      <= ld_s;
                            j      <= ld_j;
                            a_q    <= ld_a;
                            b_q    <= ld_b;
                            k_q    <= ld_pos;
                            n_q    <= ld_n;
                            last_q <= ld_last;
                        end else if (s != lmax) begin
                            state   <= GAP;
                            gcnt    <= '0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            state   <= DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (gcnt == GAP_END) begin
                        state   <= RUN;
                        s       <= ld_s;
                        j       <= ld_j;
                        a_q     <= ld_a;
                        b_q     <= ld_b;
                        k_q     <= ld_pos;
                        n_q     <= ld_n;
                        last_q  <= ld_last;
                        valid_q <= 1'b1;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.addr_a    = a_q;
    assign bus.addr_b    = b_q;
    assign bus.tw_k      = k_q;
    assign bus.tw_n      = n_q;
    assign bus.stage     = s;
    assign bus.last      = last_q;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Bench for fft_addr_gen: reference beat list built from the DIT
// butterfly formulas, randomized ready/size, abort, reset and err cases.
module tb_fft_addr_gen;

    localparam int MAX_N = 32;
    localparam int AW    = 5;
    localparam int LW    = 3;
    localparam int GAP   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [LW-1:0] n_log2;
    logic          busy;
    logic          done;
    logic          err;

    fft_addr_gen_if #(.ADDR_WIDTH(AW), .LOG2_W(LW)) bus ();

    fft_addr_gen #(.MAX_N(MAX_N), .STAGE_GAP(GAP)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .n_log2 (n_log2),
        .abort  (abort),
        .bus    (bus),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int a;
        int b;
        int k;
        int n;
        int s;
        bit last;
    } beat_t;

    beat_t expq[$];

    task automatic build(input int L);
        int nn;
        beat_t bt;
        nn = 1 << L;
        expq.delete();
        for (int st = 0; st < L; st++) begin
            for (int jj = 0; jj < nn / 2; jj++) begin
                int half;
                half    = 1 << st;
                bt.a    = (jj / half) * 2 * half + (jj % half);
                bt.b    = bt.a + half;
                bt.k    = jj % half;
                bt.n    = 2 * half;
                bt.s    = st;
                bt.last = (st == L - 1) && (jj == nn / 2 - 1);
                expq.push_back(bt);
            end
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_last", bus.last, 0);
        chk("rst_a", bus.addr_a, 0);
        chk("rst_b", bus.addr_b, 0);
        chk("rst_k", bus.tw_k, 0);
        chk("rst_n", bus.tw_n, 0);
        chk("rst_stage", bus.stage, 0);
    endtask

    // Runs one transform; abort_at >= 0 aborts on that beat index,
    // poke_cyc > 0 pulses a foreign start at that cycle.
    task automatic run(input int L, input bit rnd, input int abort_at, input int poke_cyc);
        int  cyc, idx, gaps;
        bit  pv, pr, fin, aborted, r;
        int  pa, pb, pk, pn, ps;
        build(L);
        @(negedge clk);
        start  = 1'b1;
        n_log2 = L[LW-1:0];
        @(negedge clk);
        start = 1'b0;
        cyc = 1; idx = 0; gaps = 0;
        pv = 0; pr = 0; fin = 0; aborted = 0;
        pa = 0; pb = 0; pk = 0; pn = 0; ps = 0;
        while (!fin && cyc < 3000) begin
            if (bus.out_valid) begin
                if (pv && !pr) begin
                    chk("hold_a", bus.addr_a, pa);
                    chk("hold_b", bus.addr_b, pb);
                    chk("hold_k", bus.tw_k, pk);
                    chk("hold_n", bus.tw_n, pn);
                    chk("hold_stage", bus.stage, ps);
                end
                if (idx >= expq.size()) begin
                    chk("extra_beat", idx, expq.size() - 1);
                end else begin
                    chk("addr_a", bus.addr_a, expq[idx].a);
                    chk("addr_b", bus.addr_b, expq[idx].b);
                    chk("tw_k", bus.tw_k, expq[idx].k);
                    chk("tw_n", bus.tw_n, expq[idx].n);
                    chk("stage", bus.stage, expq[idx].s);
                    chk("last", bus.last, expq[idx].last);
                end
            end else begin
                if (pv && !pr) chk("valid_drop", 0, 1);
                chk("last_invalid", bus.last, 0);
                if (busy && !done) gaps++;
            end
            if (done) begin
                chk("done_beats", idx, expq.size());
                chk("gap_cycles", gaps, (L - 1) * GAP);
                if (!rnd) chk("done_cycle", cyc, 1 + L * (1 << L) / 2 + (L - 1) * GAP);
                chk("busy_at_done", busy, 1);
                fin = 1;
            end else begin
                chk("busy", busy, 1);
                r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (abort_at >= 0 && bus.out_valid && idx == abort_at) begin
                    abort   = 1'b1;
                    r       = 1'b1;
                    aborted = 1;
                end
                if (cyc == poke_cyc) begin
                    start  = 1'b1;
                    n_log2 = 3'd2;
                end else begin
                    start = 1'b0;
                end
                bus.out_ready = r;
                pv = bus.out_valid; pr = r;
                pa = bus.addr_a; pb = bus.addr_b; pk = bus.tw_k;
                pn = bus.tw_n; ps = bus.stage;
                if (bus.out_valid && r) idx++;
                @(negedge clk);
                cyc++;
                start = 1'b0;
                if (aborted) begin
                    abort = 1'b0;
                    chk("abort_valid", bus.out_valid, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_last", bus.last, 0);
                    for (int i = 0; i < 6; i++) begin
                        chk("abort_no_done", done, 0);
                        @(negedge clk);
                    end
                    fin = 1;
                end
            end
        end
        if (!fin) chk("timeout", 0, 1);
        else if (!aborted) begin
            @(negedge clk);
            chk("post_busy", busy, 0);
            chk("post_done", done, 0);
            chk("post_valid", bus.out_valid, 0);
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic try_illegal(input logic [LW-1:0] l);
        @(negedge clk);
        start  = 1'b1;
        n_log2 = l;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_valid", bus.out_valid, 0);
        @(negedge clk);
        chk("err_clear", err, 0);
        chk("err_busy2", busy, 0);
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        n_log2        = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;

        run(3, 0, -1, -1);
        run(5, 0, -1, -1);
        run(3, 1, -1, -1);
        run(3, 0, 4, -1);
        run(2, 0, -1, -1);

        try_illegal(3'd0);
        try_illegal(3'd6);

        // abort while idle must be harmless
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);

        run(3, 0, -1, 3);

        @(negedge clk);
        start  = 1'b1;
        n_log2 = 3'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_valid", bus.out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals();
        @(negedge clk);
        chk("rst_idle_valid", bus.out_valid, 0);
        chk("rst_idle_busy", busy, 0);

        run(1, 0, -1, -1);

        repeat (5) run($urandom_range(1, 5), 1, -1, -1);
        run(4, 1, $urandom_range(0, 20), -1);
        run(5, 1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
